// File: rtl/mesh_term_src.sv
// ---------------------------------------------------------------------------
// mesh_term_src
//
// Terminal-side packet source for one mesh edge port. The local agent pushes
// packets into a small circular FIFO; the head entry is offered to the
// attached router input with the pending/pop handshake (pndng + data_out,
// router consumes with pop).
//
// Optional build macro:
//   MESH_SRC_STATS_EN  - when defined, sent_cnt/drop_cnt are real saturating
//                        counters; otherwise both ports are tied to 0. The
//                        port list is the same in both builds.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      synchronous active-high reset
//   push       agent writes push_data this cycle
//   push_data  packet to enqueue (pckg_sz bits)
//   full       FIFO holds fifo_depth entries
//   count      current occupancy
//   pndng      head packet valid toward router
//   data_out   head packet, 0 when pndng = 0
//   pop        router consumes the head this cycle
//   clear_err  clears the sticky error flags
//   ovf_err    sticky: a push was dropped
//   pop_err    sticky: pop seen while pndng = 0
//   sent_cnt   packets consumed by the router (saturating)
//   drop_cnt   pushes dropped (saturating)
// ---------------------------------------------------------------------------
module mesh_term_src #(
    parameter int pckg_sz    = 32,
    parameter int fifo_depth = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push,
    input  logic [pckg_sz-1:0]                push_data,
    output logic                              full,
    output logic [$clog2(fifo_depth+1)-1:0]   count,
    output logic                              pndng,
    output logic [pckg_sz-1:0]                data_out,
    input  logic                              pop,
    input  logic                              clear_err,
    output logic                              ovf_err,
    output logic                              pop_err,
    output logic [31:0]                       sent_cnt,
    output logic [15:0]                       drop_cnt
);

    localparam int PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int CNT_W = $clog2(fifo_depth + 1);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(fifo_depth - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(fifo_depth);

    logic [pckg_sz-1:0] mem [fifo_depth];

    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg,  count_next;
    logic             ovf_err_reg, ovf_err_next;
    logic             pop_err_reg, pop_err_next;

    logic pop_ok;
    logic push_ok;
    logic push_drop;
    logic pop_bad;

    // Handshake qualification. A push into a full FIFO is still accepted when
    // the head leaves in the same cycle: wr_ptr == rd_ptr then, so the slot
    // being overwritten is exactly the one being consumed.
    assign pndng     = (count_reg != '0);
    assign full      = (count_reg == DEPTH_CNT);
    assign pop_ok    = pop && pndng;
    assign pop_bad   = pop && !pndng;
    assign push_ok   = push && (!full || pop_ok);
    assign push_drop = push && !push_ok;

    assign count    = count_reg;
    assign data_out = pndng ? mem[rd_ptr_reg] : '0;
    assign ovf_err  = ovf_err_reg;
    assign pop_err  = pop_err_reg;

    always_comb begin
        rd_ptr_next  = rd_ptr_reg;
        wr_ptr_next  = wr_ptr_reg;
        count_next   = count_reg;
        ovf_err_next = ovf_err_reg;
        pop_err_next = pop_err_reg;

        if (pop_ok) begin
            rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
        end
        if (push_ok) begin
            wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
        end

        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase

        // A new error event in the same cycle as clear_err keeps the flag set.
        if (clear_err) begin
            ovf_err_next = 1'b0;
            pop_err_next = 1'b0;
        end
        if (push_drop) ovf_err_next = 1'b1;
        if (pop_bad)   pop_err_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            count_reg   <= '0;
            ovf_err_reg <= 1'b0;
            pop_err_reg <= 1'b0;
        end else begin
            rd_ptr_reg  <= rd_ptr_next;
            wr_ptr_reg  <= wr_ptr_next;
            count_reg   <= count_next;
            ovf_err_reg <= ovf_err_next;
            pop_err_reg <= pop_err_next;
        end
    end

    // Storage is deliberately not reset; only the pointers/occupancy are.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

`ifdef MESH_SRC_STATS_EN
    logic [31:0] sent_cnt_reg;
    logic [15:0] drop_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sent_cnt_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (pop_ok && (sent_cnt_reg != '1)) begin
                sent_cnt_reg <= sent_cnt_reg + 32'd1;
            end
            if (push_drop && (drop_cnt_reg != '1)) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end
    end

    assign sent_cnt = sent_cnt_reg;
    assign drop_cnt = drop_cnt_reg;
`else
    assign sent_cnt = '0;
    assign drop_cnt = '0;
`endif

endmodule

// File: doc/mesh_term_src.md
# mesh_term_src

Terminal-side packet source for one mesh edge port. Buffers packets written by the local agent in a `fifo_depth`-entry FIFO and presents the head packet to the attached router input using the pending/pop handshake: `pndng` plus `data_out` offered, router consumes with `pop`. One instance sits on each of the `rows*2+colums*2` terminal ports, opposite the router's input pop logic.

## Interface
- `pckg_sz`, default 32: packet width in bits.
- `fifo_depth`, default 4: FIFO entries; must be 2 or more; need not be a power of two.
- `clk`  input  1: clock; all state updates on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `push`  input  1: local agent writes `push_data` this cycle.
- `push_data`  input  pckg_sz: packet to enqueue.
- `full`  output  1: FIFO holds `fifo_depth` entries.
- `count`  output  $clog2(fifo_depth+1): current occupancy.
- `pndng`  output  1: head packet valid toward router.
- `data_out`  output  pckg_sz: head packet; 0 when `pndng`=0.
- `pop`  input  1: router consumes head this cycle.
- `clear_err`  input  1: clears sticky error flags.
- `ovf_err`  output  1: sticky; a push was dropped.
- `pop_err`  output  1: sticky; `pop` was seen while `pndng`=0.
- `sent_cnt`  output  32: packets popped by the router (stats).
- `drop_cnt`  output  16: pushes dropped (stats).

## Operation
- Circular buffer with read pointer, write pointer and occupancy counter. Pointers wrap from `fifo_depth-1` to 0.
- `pndng` = (`count` != 0). `data_out` = storage[rd_ptr] when `pndng`=1, else 0. Both are derived only from registers, with no combinational path from `push` or `pop`.
- Pop is accepted when `pop`=1 and `pndng`=1: rd_ptr advances, `count` decrements, `sent_cnt` increments.
- Pop with `pndng`=0 is ignored and sets `pop_err`.
- Push is accepted when `push`=1 and either `full`=0 or (`full`=1 and pop accepted in the same cycle):
  - data is written at wr_ptr;
  - wr_ptr advances.
- A rejected push is discarded. It sets `ovf_err` and increments `drop_cnt`. No stored entry changes.
- Simultaneous accepted push and pop: `count` is unchanged and both pointers advance. On an empty FIFO the pop is invalid (see above) and the push is accepted normally.
- Head stability: while `pndng`=1 and no pop is accepted, `data_out` must not change, including when pushes occur.
- `clear_err`=1 clears `ovf_err` and `pop_err`. If an error event occurs in the same cycle, the flag stays 1 (set wins).
- Counters saturate at all-ones and do not wrap. They are not cleared by `clear_err`.

## Timing
- Reset: pointers 0, `count`=0, `full`=0, `pndng`=0, `data_out`=0, `ovf_err`=0, `pop_err`=0, `sent_cnt`=0, `drop_cnt`=0. Storage contents are not reset.
- Reset mid-operation discards all queued packets. `pndng` is 0 in the first cycle after reset is sampled.
- Push-to-pndng latency: 1 cycle. A push into an empty FIFO at edge N gives `pndng`=1 and `data_out`=pushed value after edge N.
- Pop-to-next-head latency: 1 cycle. After an accepted pop at edge N, the next entry appears after edge N, or `pndng`=0 if the FIFO is now empty.
- Back-to-back pops every cycle are supported, giving a throughput of one packet per cycle.
- `full` and `count` update at the same edge as the push or pop that changes them.

## Configuration
- `MESH_SRC_STATS_EN` defined: `sent_cnt` and `drop_cnt` are implemented as described.
- Not defined: the counter registers are removed and both ports are tied to 0. `ovf_err` and `pop_err` stay functional. The port list is identical in both builds.

## Test plan
- Reset, then push 0xA5A5_0001 at cycle 2 -> `pndng`=1 with `data_out`=0xA5A5_0001 from cycle 3; `pop` at cycle 5 -> `pndng`=0 and `data_out`=0 from cycle 6; `sent_cnt`=1.
- `fifo_depth`=4: push 1, 2, 3, 4 on consecutive cycles, then push 5 -> `full`=1, `count`=4, `ovf_err`=1, `drop_cnt`=1. Four pops then return 1, 2, 3, 4 in order and packet 5 never appears.
- FIFO full, push 9 with `pop` in the same cycle -> 1 is consumed, 9 is accepted, `count` stays 4, `ovf_err` stays 0; the final pop order ends with ...4, 9.
- `pop`=1 while empty -> `pop_err`=1, `count` stays 0. Assert `clear_err` -> `pop_err`=0 the next cycle. `clear_err` together with an empty pop -> `pop_err` remains 1.
- Hold `pndng`=1 with no pop for 10 cycles while pushing 2 more packets -> `data_out` is unchanged every cycle.
- Fill to 3 entries, assert `reset` for 1 cycle -> `pndng`=0, `count`=0, `data_out`=0 next cycle; counters are 0 (or always 0 without `MESH_SRC_STATS_EN`).
